shr4bit_serial: RTL

//  Sequential right-shift unit; the right-shift counterpart to the ALU's

---
 rtl/shr4bit_serial.sv | 103 ++++++++++
 1 files changed

// File: rtl/shr4bit_serial.sv
// Serial right shifter: shifts A right by B[SHAMT_W-1:0], one bit per clock, logical or arithmetic.
// Latency: start accepted at edge k -> done (with R valid) high from edge k+shamt+1 for one cycle.
// Backpressure: start ignored while busy; start in the done cycle is accepted back-to-back.
module shr4bit_serial #(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             arith,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     acc_q,   acc_d;
    logic [SHAMT_W-1:0]   cnt_q,   cnt_d;
    logic                 mode_q,  mode_d;
    logic [WIDTH-1:0]     r_q,     r_d;
    logic                 done_q,  done_d;

    // Upper bits of B never affect the shift amount.
    logic unused_b_hi;
    assign unused_b_hi = ^B[WIDTH-1:SHAMT_W];

    // Next-state logic: load on accepted start, shift while cnt is non-zero, publish R when cnt hits zero.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        r_d     = r_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = A;
                    cnt_d   = B[SHAMT_W-1:0];
                    mode_d  = arith;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    // Fill with the current MSB in arithmetic mode so negatives saturate at all-ones.
                    acc_d = {(mode_q ? acc_q[WIDTH-1] : 1'b0), acc_q[WIDTH-1:1]};
                    cnt_d = cnt_q - SHAMT_W'(1);
                end else begin
                    r_d     = acc_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start here chains directly into the next op without an idle bubble.
                if (start) begin
                    acc_d   = A;
                    cnt_d   = B[SHAMT_W-1:0];
                    mode_d  = arith;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset aborts any op in flight with no done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = done_q;
    assign R    = r_q;

endmodule
